shift_seq_ctrl: RTL and testbench

Sequencer for an N-bit shift register used as a full-duplex serial engine. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per `tick` strobe, MSB-first or LSB-first. At the same time it shifts `ser_in` into the vacated positions and, after WIDTH ticks, presents the received word on a valid/ready output. It sits between parallel producer/consumer logic and any bit-serial link (SPI-like, loopback, scan).

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_core.sv | 32 +++
 rtl/shift_seq_ctrl.sv | 97 +++++++++
 tb/tb_shift_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer: FSM state encoding and
// the meaning of the dir input.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;  // MSB-first
  localparam logic DIR_RIGHT = 1'b1;  // LSB-first

endpackage

// File: rtl/shift_core.sv
// Shift register datapath: parallel load, or one shift per enable with the
// serial input entering the vacated end.
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (arst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        q <= {ser_in, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], ser_in};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial engine sequencer: loads a word, shifts it out one bit per
// tick while shifting ser_in in, then offers the received word.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             tick,
  input  logic             dir,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic [WIDTH-1:0] sreg;
  logic             load;
  logic             shift_en;

  // Handshakes: a word moves when valid and ready are both high on a rising
  // edge; valid and data stay stable until that edge, ready may depend on
  // state only (never on the partner's valid).
  assign load     = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT) && tick;

  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            cnt   <= '0;
            dir_q <= dir;
          end
        end
        SHIFT: begin
          if (tick) begin
            // The last shift leaves cnt at WIDTH-1 so it cannot wrap.
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .arst     (arst),
    .load     (load),
    .load_data(in_data),
    .shift_en (shift_en),
    .dir      (dir_q),
    .ser_in   (ser_in),
    .q        (sreg)
  );

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
    out_data  = (state == DONE) ? sreg : '0;
    ser_out   = 1'b0;
    if (state == SHIFT) begin
      ser_out = (dir_q == DIR_RIGHT) ? sreg[0] : sreg[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written
// reset/abort sequence, and randomized transfers against a bit-order model.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst;
  logic         tick;
  logic         dir;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         ser_in;
  logic         ser_out;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         loop_en;
  logic         ser_drv;

  assign ser_in = loop_en ? ser_out : ser_drv;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .arst     (arst),
    .tick     (tick),
    .dir      (dir),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // i-th transmitted bit: MSB-first for left, LSB-first for right.
  function automatic logic tx_bit(input logic d, input logic [W-1:0] data, input int i);
    return d ? data[i] : data[W-1-i];
  endfunction

  // rx bit i is the i-th bit received; left shift ends with the first bit at
  // the MSB, right shift ends with it at the LSB.
  function automatic logic [W-1:0] model_word(input logic d, input logic [W-1:0] rx);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[d ? i : W-1-i] = rx[i];
    return w;
  endfunction

  function automatic logic [W-1:0] model_tx(input logic d, input logic [W-1:0] data);
    logic [W-1:0] t;
    for (int i = 0; i < W; i++) t[i] = tx_bit(d, data, i);
    return t;
  endfunction

  // ---------------- driver ----------------
  // tper: 0 = random tick, k = tick on every k-th cycle of SHIFT.
  task automatic xfer(input logic d, input logic [W-1:0] data, input logic [W-1:0] rx,
                      input bit lp, input int tper, input bit tog, input int hold,
                      input logic [W-1:0] exp_word,
                      output logic [W-1:0] tx, output int lat);
    int n;
    logic [W-1:0] e;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    loop_en   = lp;
    in_valid  = 1'b1;
    in_data   = data;
    dir       = d;
    tick      = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(exp_word);
    n   = 0;
    lat = 0;
    tx  = '0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    lat      = 1;
    while (n < W && lat < 400) begin
      chk("busy_shift", 32'(busy), 32'd1);
      chk("in_ready_shift", 32'(in_ready), 32'd0);
      chk("out_valid_shift", 32'(out_valid), 32'd0);
      chk("ser_out", 32'(ser_out), 32'(tx_bit(d, data, n)));
      tick = (tper == 0) ? 1'($urandom_range(0, 1)) : ((lat % tper) == 0);
      if (tog) dir = ~dir;
      if (tick) begin
        tx[n]   = ser_out;
        ser_drv = rx[n];
        n++;
      end
      @(negedge clk);
      lat++;
    end
    tick = 1'b0;
    if (n < W) chk("shift_timeout", 32'(n), 32'(W));
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid_done", 32'(out_valid), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("in_ready_done", 32'(in_ready), 32'd0);
      chk("ser_out_done", 32'(ser_out), 32'd0);
      chk("out_data", 32'(out_data), 32'(e));
      if (h < hold) begin
        in_valid  = 1'($urandom_range(0, 1));
        tick      = 1'($urandom_range(0, 1));
        in_data   = W'($urandom);
        dir       = ~dir;
        out_ready = 1'b0;
      end else begin
        in_valid  = 1'b0;
        tick      = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("out_data_after", 32'(out_data), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         d;
    logic [W-1:0] data;
    logic [W-1:0] rx;
    bit           lp;
    int           tper;
    bit           tog;
    int           hold;
    logic [W-1:0] exp_tx;
    logic [W-1:0] exp_out;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] tx;
    int           lat;
    logic         d;
    logic [W-1:0] data;
    logic [W-1:0] rx;
    bit           lp;

    //            d     data   rx     lp tper tog hold exp_tx exp_out lat
    vecs[0] = '{1'b0, 8'hA5, 8'h00, 1, 1, 0, 0, 8'hA5, 8'hA5, 9};   // loopback MSB-first
    vecs[1] = '{1'b1, 8'h01, 8'hFF, 0, 1, 0, 0, 8'h01, 8'hFF, 9};   // ser_in constant 1
    vecs[2] = '{1'b0, 8'hC3, 8'h00, 1, 3, 0, 0, 8'hC3, 8'hC3, 25};  // tick every 3rd cycle
    vecs[3] = '{1'b1, 8'h3C, 8'h00, 1, 1, 0, 5, 8'h3C, 8'h3C, 9};   // consumer stalls in DONE
    vecs[4] = '{1'b1, 8'h9E, 8'h53, 0, 1, 1, 0, 8'h9E, 8'h53, 9};   // dir toggles while shifting
    vecs[5] = '{1'b0, 8'h81, 8'h00, 0, 1, 0, 0, 8'h81, 8'h00, 9};
    vecs[6] = '{1'b0, 8'h0F, 8'h80, 0, 1, 0, 0, 8'hF0, 8'h01, 9};   // last bit lands at LSB
    vecs[7] = '{1'b1, 8'hB4, 8'h01, 0, 2, 0, 1, 8'hB4, 8'h01, 17};  // first bit lands at LSB

    arst = 1'b1; tick = 1'b0; dir = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; loop_en = 1'b0; ser_drv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    arst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].d, vecs[i].data, vecs[i].rx, vecs[i].lp, vecs[i].tper, vecs[i].tog,
           vecs[i].hold, vecs[i].exp_out, tx, lat);
      chk($sformatf("vec%0d_tx", i), 32'(tx), 32'(vecs[i].exp_tx));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Abort mid-transfer: reset after three ticks drops the word.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hF0; dir = 1'b0; loop_en = 1'b0; ser_drv = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    chk("abort_ser_out_before", 32'(ser_out), 32'(tx_bit(1'b0, 8'hF0, 3)));
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_ser_out", 32'(ser_out), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", 32'(out_valid), 32'd0);
      chk("abort_idle", 32'(in_ready), 32'd1);
    end
    tick = 1'b0;
    xfer(1'b0, 8'h5A, 8'h00, 1, 1, 0, 0, 8'h5A, tx, lat);
    chk("after_abort_lat", 32'(lat), 32'd9);

    // Randomized transfers against the bit-order model.
    for (int i = 0; i < 30; i++) begin
      d    = 1'($urandom_range(0, 1));
      data = W'($urandom);
      rx   = W'($urandom);
      lp   = ($urandom_range(0, 3) == 0);
      xfer(d, data, rx, lp, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2), lp ? data : model_word(d, rx), tx, lat);
      chk("rand_tx", 32'(tx), 32'(model_tx(d, data)));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
